// File: rtl/axi_pkg.sv
// Shared AXI constants, FSM state types and a debug snapshot for the RAM slave.
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] RESP_OKAY   = 2'b00;

  typedef enum logic [0:0] {
    W_IDLE  = 1'b0,
    W_BURST = 1'b1
  } wr_state_t;

  typedef enum logic [0:0] {
    R_IDLE  = 1'b0,
    R_BURST = 1'b1
  } rd_state_t;

  typedef struct packed {
    wr_state_t  wr_state;
    rd_state_t  rd_state;
    logic [7:0] wr_beat;
    logic [7:0] rd_beat;
  } fsm_dbg_t;

  function automatic logic [7:0] beat_bytes(input logic [2:0] size);
    return 8'd1 << size;
  endfunction

endpackage

// File: rtl/axi_ram_rd_pipe.sv
// One-entry valid/ready register slice placed on the R channel when output pipelining is enabled.
module axi_ram_rd_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  // valid/ready: a transfer happens on a rising edge where valid && ready; the
  // sender holds data stable while valid && !ready.
  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) out_data <= in_data;
    end
  end

endmodule

// File: rtl/axi_ram_slave.sv
// AXI4 memory slave: one write burst and one read burst in flight, always-OKAY responses.
module axi_ram_slave
  import axi_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 16,
  parameter int STRB_WIDTH      = DATA_WIDTH / 8,
  parameter int ID_WIDTH        = 8,
  parameter int PIPELINE_OUTPUT = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ID_WIDTH-1:0]   s_axi_awid,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [7:0]            s_axi_awlen,
  input  logic [2:0]            s_axi_awsize,
  input  logic [1:0]            s_axi_awburst,
  input  logic                  s_axi_awlock,
  input  logic [3:0]            s_axi_awcache,
  input  logic [2:0]            s_axi_awprot,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [DATA_WIDTH-1:0] s_axi_wdata,
  input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
  input  logic                  s_axi_wlast,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [ID_WIDTH-1:0]   s_axi_bid,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ID_WIDTH-1:0]   s_axi_arid,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [7:0]            s_axi_arlen,
  input  logic [2:0]            s_axi_arsize,
  input  logic [1:0]            s_axi_arburst,
  input  logic                  s_axi_arlock,
  input  logic [3:0]            s_axi_arcache,
  input  logic [2:0]            s_axi_arprot,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [ID_WIDTH-1:0]   s_axi_rid,
  output logic [DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready
);

  localparam int OFF  = $clog2(STRB_WIDTH);
  localparam int IDXW = ADDR_WIDTH - OFF;

  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                      input logic [2:0] size,
                                                      input logic [1:0] burst);
    case (burst)
      BURST_INCR, BURST_WRAP: next_addr = a + ADDR_WIDTH'(beat_bytes(size));
      BURST_FIXED:            next_addr = a;
      default:                next_addr = a;
    endcase
  endfunction

  logic [DATA_WIDTH-1:0] mem [0:(1<<IDXW)-1];

  // Readies stay low until the first edge after reset is released.
  logic ready_en;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ready_en <= 1'b0;
    else     ready_en <= 1'b1;
  end

  wr_state_t             wr_state;
  logic [ID_WIDTH-1:0]   wr_id;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [7:0]            wr_len, wr_cnt;
  logic [2:0]            wr_size;
  logic [1:0]            wr_burst;
  logic                  aw_fire, w_fire;
  logic [IDXW-1:0]       w_idx;

  assign s_axi_awready = ready_en && (wr_state == W_IDLE) && !(s_axi_bvalid && !s_axi_bready);
  assign s_axi_wready  = (wr_state == W_BURST);
  assign s_axi_bresp   = RESP_OKAY;
  assign aw_fire       = s_axi_awvalid && s_axi_awready;
  assign w_fire        = s_axi_wvalid && s_axi_wready;
  assign w_idx         = wr_addr[ADDR_WIDTH-1:OFF];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_state     <= W_IDLE;
      wr_id        <= '0;
      wr_addr      <= '0;
      wr_len       <= '0;
      wr_cnt       <= '0;
      wr_size      <= '0;
      wr_burst     <= '0;
      s_axi_bvalid <= 1'b0;
      s_axi_bid    <= '0;
    end else begin
      if (s_axi_bvalid && s_axi_bready) s_axi_bvalid <= 1'b0;
      case (wr_state)
        W_IDLE: begin
          if (aw_fire) begin
            wr_id    <= s_axi_awid;
            wr_addr  <= s_axi_awaddr;
            wr_len   <= s_axi_awlen;
            wr_size  <= s_axi_awsize;
            wr_burst <= s_axi_awburst;
            wr_cnt   <= '0;
            wr_state <= W_BURST;
          end
        end
        W_BURST: begin
          if (w_fire) begin
            wr_addr <= next_addr(wr_addr, wr_size, wr_burst);
            wr_cnt  <= wr_cnt + 8'd1;
            if (wr_cnt == wr_len || s_axi_wlast) begin
              s_axi_bvalid <= 1'b1;
              s_axi_bid    <= wr_id;
              wr_state     <= W_IDLE;
            end
          end
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  // Memory contents survive reset.
  always_ff @(posedge clk) begin
    if (w_fire) begin
      for (int i = 0; i < STRB_WIDTH; i++) begin
        if (s_axi_wstrb[i]) mem[w_idx][i*8 +: 8] <= s_axi_wdata[i*8 +: 8];
      end
    end
  end

  rd_state_t             rd_state;
  logic [ID_WIDTH-1:0]   rd_id;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [7:0]            rd_len, rd_cnt;
  logic [2:0]            rd_size;
  logic [1:0]            rd_burst;
  logic                  ar_fire, rd_issue;
  logic [IDXW-1:0]       r_idx;
  logic                  r_valid_q, r_last_q, r_stage_ready;
  logic [ID_WIDTH-1:0]   r_id_q;
  logic [DATA_WIDTH-1:0] r_data_q;

  assign s_axi_arready = ready_en && (rd_state == R_IDLE);
  assign s_axi_rresp   = RESP_OKAY;
  assign ar_fire       = s_axi_arvalid && s_axi_arready;
  assign rd_issue      = (rd_state == R_BURST) && (!r_valid_q || r_stage_ready);
  assign r_idx         = rd_addr[ADDR_WIDTH-1:OFF];

  // Synchronous read with non-blocking update gives old data on a same-cycle write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_state  <= R_IDLE;
      rd_id     <= '0;
      rd_addr   <= '0;
      rd_len    <= '0;
      rd_cnt    <= '0;
      rd_size   <= '0;
      rd_burst  <= '0;
      r_valid_q <= 1'b0;
      r_last_q  <= 1'b0;
      r_id_q    <= '0;
      r_data_q  <= '0;
    end else begin
      if (r_valid_q && r_stage_ready) r_valid_q <= 1'b0;
      case (rd_state)
        R_IDLE: begin
          if (ar_fire) begin
            rd_id    <= s_axi_arid;
            rd_addr  <= s_axi_araddr;
            rd_len   <= s_axi_arlen;
            rd_size  <= s_axi_arsize;
            rd_burst <= s_axi_arburst;
            rd_cnt   <= '0;
            rd_state <= R_BURST;
          end
        end
        R_BURST: begin
          if (rd_issue) begin
            r_valid_q <= 1'b1;
            r_data_q  <= mem[r_idx];
            r_id_q    <= rd_id;
            r_last_q  <= (rd_cnt == rd_len);
            rd_addr   <= next_addr(rd_addr, rd_size, rd_burst);
            rd_cnt    <= rd_cnt + 8'd1;
            if (rd_cnt == rd_len) rd_state <= R_IDLE;
          end
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

  generate
    if (PIPELINE_OUTPUT != 0) begin : g_pipe
      axi_ram_rd_pipe #(.WIDTH(ID_WIDTH + DATA_WIDTH + 1)) u_rd_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_data   ({r_id_q, r_data_q, r_last_q}),
        .in_valid  (r_valid_q),
        .in_ready  (r_stage_ready),
        .out_data  ({s_axi_rid, s_axi_rdata, s_axi_rlast}),
        .out_valid (s_axi_rvalid),
        .out_ready (s_axi_rready)
      );
    end else begin : g_direct
      assign s_axi_rid     = r_id_q;
      assign s_axi_rdata   = r_data_q;
      assign s_axi_rlast   = r_last_q;
      assign s_axi_rvalid  = r_valid_q;
      assign r_stage_ready = s_axi_rready;
    end
  endgenerate

  fsm_dbg_t dbg;
  assign dbg = '{wr_state: wr_state, rd_state: rd_state, wr_beat: wr_cnt, rd_beat: rd_cnt};

  logic unused_inputs;
  assign unused_inputs = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot,
                           s_axi_arlock, s_axi_arcache, s_axi_arprot, dbg};

endmodule

// File: tb/tb_axi_ram_slave.sv
// Directed bench for axi_ram_slave (8-bit data, 16-bit address, no output pipeline).
module tb_axi_ram_slave;
  import axi_pkg::*;

  localparam int DW = 8;
  localparam int AW = 16;
  localparam int IW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [IW-1:0] awid, arid, bid, rid;
  logic [AW-1:0] awaddr, araddr;
  logic [7:0]    awlen, arlen;
  logic [2:0]    awsize, arsize, awprot, arprot;
  logic [1:0]    awburst, arburst, bresp, rresp;
  logic          awlock, arlock;
  logic [3:0]    awcache, arcache;
  logic          awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rlast, rvalid, rready;
  logic [DW-1:0] wdata, rdata;
  logic [0:0]    wstrb;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  axi_ram_slave #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(1), .ID_WIDTH(IW), .PIPELINE_OUTPUT(0)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
    .s_axi_awburst(awburst), .s_axi_awlock(awlock), .s_axi_awcache(awcache), .s_axi_awprot(awprot),
    .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast), .s_axi_wvalid(wvalid),
    .s_axi_wready(wready),
    .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize),
    .s_axi_arburst(arburst), .s_axi_arlock(arlock), .s_axi_arcache(arcache), .s_axi_arprot(arprot),
    .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // All driver tasks start and end at a falling edge.
  task automatic send_aw(input logic [15:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input logic [7:0] id);
    int n = 0;
    awid = id; awaddr = addr; awlen = len; awsize = 3'd0; awburst = burst; awvalid = 1'b1;
    while (!awready && n < 20) begin @(negedge clk); n++; end
    if (!awready) check("aw_timeout", 32'(awready), 32'd1);
    else @(posedge clk);
    @(negedge clk);
    awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [7:0] data, input logic last);
    int n = 0;
    wdata = data; wstrb = 1'b1; wlast = last; wvalid = 1'b1;
    while (!wready && n < 20) begin @(negedge clk); n++; end
    if (!wready) check("w_timeout", 32'(wready), 32'd1);
    else @(posedge clk);
    @(negedge clk);
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic expect_b(input logic [7:0] id);
    int n = 0;
    while (!bvalid && n < 20) begin @(negedge clk); n++; end
    check("bvalid", 32'(bvalid), 32'd1);
    check("bid", 32'(bid), 32'(id));
    check("bresp", 32'(bresp), 32'(RESP_OKAY));
    @(posedge clk);
    @(negedge clk);
    check("bvalid_cleared", 32'(bvalid), 32'd0);
  endtask

  task automatic send_ar(input logic [15:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input logic [7:0] id);
    int n = 0;
    arid = id; araddr = addr; arlen = len; arsize = 3'd0; arburst = burst; arvalid = 1'b1;
    while (!arready && n < 20) begin @(negedge clk); n++; end
    if (!arready) check("ar_timeout", 32'(arready), 32'd1);
    else @(posedge clk);
    @(negedge clk);
    arvalid = 1'b0;
  endtask

  task automatic expect_r(input string tag, input logic [7:0] data,
                          input logic [7:0] id, input logic last);
    int n = 0;
    while (!rvalid && n < 20) begin @(negedge clk); n++; end
    check({tag, "_rvalid"}, 32'(rvalid), 32'd1);
    check({tag, "_rdata"}, 32'(rdata), 32'(data));
    check({tag, "_rid"}, 32'(rid), 32'(id));
    check({tag, "_rlast"}, 32'(rlast), 32'(last));
    check({tag, "_rresp"}, 32'(rresp), 32'(RESP_OKAY));
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awlock = 1'b0;
    awcache = '0; awprot = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b1;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arlock = 1'b0;
    arcache = '0; arprot = '0; arvalid = 1'b0; rready = 1'b1;
    rst = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_awready", 32'(awready), 32'd0);
    check("rst_wready", 32'(wready), 32'd0);
    check("rst_arready", 32'(arready), 32'd0);
    check("rst_bvalid", 32'(bvalid), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_rlast", 32'(rlast), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    check("rst_rid", 32'(rid), 32'd0);
    check("rst_bid", 32'(bid), 32'd0);
    rst = 1'b0;
    #1;
    check("rel_arready_low", 32'(arready), 32'd0);
    @(negedge clk);
    check("rel_arready", 32'(arready), 32'd1);
    check("rel_awready", 32'(awready), 32'd1);

    // Single-beat write and read with exact read latency
    send_aw(16'h0eef, 8'd0, BURST_INCR, 8'd5);
    send_w(8'hA5, 1'b1);
    expect_b(8'd5);
    send_ar(16'h0eef, 8'd0, BURST_INCR, 8'd5);
    check("lat_rvalid_early", 32'(rvalid), 32'd0);
    @(negedge clk);
    check("lat_rvalid", 32'(rvalid), 32'd1);
    check("lat_rdata", 32'(rdata), 32'hA5);
    check("lat_rid", 32'(rid), 32'd5);
    check("lat_rlast", 32'(rlast), 32'd1);
    check("lat_rresp", 32'(rresp), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("lat_rvalid_done", 32'(rvalid), 32'd0);

    // INCR burst write and read back
    send_aw(16'h0100, 8'd3, BURST_INCR, 8'd3);
    send_w(8'd1, 1'b0);
    send_w(8'd2, 1'b0);
    send_w(8'd3, 1'b0);
    send_w(8'd4, 1'b1);
    expect_b(8'd3);
    send_ar(16'h0100, 8'd3, BURST_INCR, 8'd9);
    expect_r("incr0", 8'd1, 8'd9, 1'b0);
    expect_r("incr1", 8'd2, 8'd9, 1'b0);
    expect_r("incr2", 8'd3, 8'd9, 1'b0);
    expect_r("incr3", 8'd4, 8'd9, 1'b1);
    check("incr_rvalid_done", 32'(rvalid), 32'd0);

    // FIXED read repeats one word
    send_ar(16'h0100, 8'd2, BURST_FIXED, 8'd2);
    expect_r("fixr0", 8'd1, 8'd2, 1'b0);
    expect_r("fixr1", 8'd1, 8'd2, 1'b0);
    expect_r("fixr2", 8'd1, 8'd2, 1'b1);

    // FIXED write: both beats land on 0x0100, neighbour untouched
    send_aw(16'h0100, 8'd1, BURST_FIXED, 8'd4);
    send_w(8'd7, 1'b0);
    send_w(8'd9, 1'b1);
    expect_b(8'd4);
    send_ar(16'h0100, 8'd0, BURST_INCR, 8'd1);
    expect_r("fixw_100", 8'd9, 8'd1, 1'b1);
    send_ar(16'h0101, 8'd0, BURST_INCR, 8'd1);
    expect_r("fixw_101", 8'd2, 8'd1, 1'b1);

    // Read back-pressure for 10 cycles mid-burst
    send_ar(16'h0100, 8'd3, BURST_INCR, 8'd6);
    expect_r("bp0", 8'd9, 8'd6, 1'b0);
    rready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("bp_hold_rvalid", 32'(rvalid), 32'd1);
      check("bp_hold_rdata", 32'(rdata), 32'd2);
      check("bp_hold_rlast", 32'(rlast), 32'd0);
      check("bp_hold_arready", 32'(arready), 32'd0);
      @(negedge clk);
    end
    rready = 1'b1;
    expect_r("bp1", 8'd2, 8'd6, 1'b0);
    expect_r("bp2", 8'd3, 8'd6, 1'b0);
    expect_r("bp3", 8'd4, 8'd6, 1'b1);
    check("bp_arready_after", 32'(arready), 32'd1);
    check("bp_rvalid_done", 32'(rvalid), 32'd0);

    // Reset in the middle of a len7 read
    send_ar(16'h0100, 8'd7, BURST_INCR, 8'd7);
    expect_r("mid0", 8'd9, 8'd7, 1'b0);
    expect_r("mid1", 8'd2, 8'd7, 1'b0);
    rst = 1'b1;
    #1;
    check("mid_rst_rvalid", 32'(rvalid), 32'd0);
    check("mid_rst_arready", 32'(arready), 32'd0);
    check("mid_rst_rlast", 32'(rlast), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_rvalid", 32'(rvalid), 32'd0);
    check("post_rst_arready", 32'(arready), 32'd1);
    send_ar(16'h0eef, 8'd0, BURST_INCR, 8'd8);
    expect_r("keep_eef", 8'hA5, 8'd8, 1'b1);
    send_ar(16'h0102, 8'd0, BURST_INCR, 8'd8);
    expect_r("keep_102", 8'd3, 8'd8, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
